// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBUS types and small helpers used by the arbiter slice.
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ADDR_W = 16;
  localparam int CBUS_DATA_W = 32;

  // Request from a master towards the downstream bus.
  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_DATA_W-1:0] wdata;
  } cbus_req_t;

  // Response beat from the downstream bus; last marks the final beat.
  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic [CBUS_DATA_W-1:0] rdata;
  } cbus_resp_t;

  // Width of a port index; never below one bit so a single port still has a signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bundle of the arbiter's request/response ports. The arbiter uses the
// slave view; the requesters and downstream model use the master view.
interface cbus_rr_arbiter_if
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2
);
  localparam int IDX_W = idx_width(NUM_INPUTS);

  cbus_req_t  [NUM_INPUTS-1:0] ireqs;
  cbus_resp_t [NUM_INPUTS-1:0] iresps;
  cbus_req_t                   oreq;
  cbus_resp_t                  oresp;
  logic                        busy;
  logic       [IDX_W-1:0]      grant_idx;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq,
    output busy,
    output grant_idx
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq,
    input  busy,
    input  grant_idx
  );
endinterface

// File: rtl/cbus_rr_arbiter_pick.sv
// Rotating-priority search: first set bit of valid_i at or above ptr_i,
// wrapping from the top index back to 0. Purely combinational.
module cbus_rr_pick #(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = 1
) (
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [IDX_W-1:0]      ptr_i,
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Scan offsets from farthest to nearest so the nearest valid port wins.
  always_comb begin
    int cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int off = NUM_INPUTS - 1; off >= 0; off--) begin
      cand    = (int'(ptr_i) + off) % NUM_INPUTS;
      found_o = valid_i[cand] ? 1'b1 : found_o;
      idx_o   = valid_i[cand] ? IDX_W'(cand) : idx_o;
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBUS arbiter. A winner is chosen in IDLE (rotating or fixed
// priority), then owns the downstream bus until a response beat with last.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int FAST_GRANT  = 0
) (
  input logic              clk,
  input logic              reset,
  cbus_rr_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_INPUTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic       [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic       [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic       [NUM_INPUTS-1:0] valid_vec;
  logic       [IDX_W-1:0]      pick_ptr;
  logic                        pick_found;
  logic       [IDX_W-1:0]      pick_idx;
  cbus_req_t                   oreq_mux;
  cbus_resp_t [NUM_INPUTS-1:0] iresps_mux;

  // Pointer value after a completion by port cur: one past it, wrapping.
  // Fixed priority never moves the pointer.
  function automatic logic [IDX_W-1:0] advance(input logic [IDX_W-1:0] cur,
                                               input logic [IDX_W-1:0] ptr);
    if (ROUND_ROBIN == 0) begin
      return ptr;
    end else if (int'(cur) >= NUM_INPUTS - 1) begin
      return '0;
    end else begin
      return cur + IDX_W'(1);
    end
  endfunction

  // Collect the per-port valid bits for the priority search.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valid_vec[i] = bus.ireqs[i].valid;
    end
  end

  // Fixed priority is the rotating search anchored at port 0.
  assign pick_ptr = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

  cbus_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .valid_i (valid_vec),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state and routing; everything stays quiet while reset is asserted.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    oreq_mux    = '0;
    iresps_mux  = '0;
    if (reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!pick_found) begin
            state_d = ST_IDLE;
          end else if (FAST_GRANT == 0) begin
            state_d     = ST_BUSY;
            grant_idx_d = pick_idx;
          end else begin
            oreq_mux             = bus.ireqs[pick_idx];
            iresps_mux[pick_idx] = bus.oresp;
            if (bus.oresp.last) begin
              // Single-beat transfer finished in the selection cycle.
              state_d  = ST_IDLE;
              rr_ptr_d = advance(pick_idx, rr_ptr_q);
            end else begin
              state_d     = ST_BUSY;
              grant_idx_d = pick_idx;
            end
          end
        end
        ST_BUSY: begin
          oreq_mux                = bus.ireqs[grant_idx_q];
          iresps_mux[grant_idx_q] = bus.oresp;
          if (bus.oresp.last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = advance(grant_idx_q, rr_ptr_q);
          end else begin
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, owner and priority pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.busy      = (state_q == ST_BUSY) && !reset;
  assign bus.grant_idx = grant_idx_q;
  assign bus.oreq      = oreq_mux;
  assign bus.iresps    = iresps_mux;

endmodule
